instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction memory. It accepts a byte stream (from the UART/debug receiver) over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word to the instruction memory write port at incrementing addresses, stopping after the all-ones halt word. While loading, it holds the pipeline in reset-hold and releases it only on successful completion.

Parameters:
DEPTH, 32, number of instruction memory words
ADDR_W, 5, write address width (log2 DEPTH)
DATA_W, 32, instruction width; fixed at 4 bytes
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory like any other word

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
in_byte  in  8  received byte
in_valid  in  1  in_byte valid
in_ready  out  1  loader accepts a byte this cycle
wr_en  out  1  instruction memory write strobe, one cycle per word
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
word_count  out  ADDR_W+1  words written in the current or last load, halt word included
busy  out  1  high in COLLECT and WRITE
done  out  1  high in DONE
overflow_err  out  1  high in ERROR
cpu_hold  out  1  keeps the pipeline/PC frozen; low only in DONE

Behaviour:
- Reset values (async, rst_n=0): state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0, busy=0, done=0, overflow_err=0, cpu_hold=1. Byte counter and shift register are cleared. Memory contents are not the loader's concern.
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start -> COLLECT.
  - On this transition: addr=0, byte_cnt=0, word_count=0, done=0, overflow_err=0.
  - start in COLLECT/WRITE is ignored.
- COLLECT:
  - in_ready=1.
  - Each edge with in_valid&in_ready shifts the byte in: word = {word[23:0], in_byte}. The first byte lands in bits 31:24.
  - byte_cnt counts 0..3 and wraps to 0.
  - The 4th accepted byte moves the state to WRITE.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=addr, wr_data=word, in_ready=0. Bytes held on in_valid wait.
  - word_count increments at the end of this cycle.
  - Next state:
    - word==HALT_WORD -> DONE.
    - else addr==DEPTH-1 -> ERROR (memory full with no halt word).
    - else addr+1 and back to COLLECT.
- Latency: the 4th byte accepted at edge N puts wr_en high in cycle N..N+1 (memory samples at edge N+1). done/overflow_err assert the cycle after the final write.
- DONE: done=1, cpu_hold=0, in_ready=0. Outputs are stable until start or reset.
- ERROR: overflow_err=1 (sticky), cpu_hold=1, in_ready=0.
- Address does not wrap. There is never a write beyond DEPTH-1.
- wr_addr/wr_data hold their last values when wr_en=0. Consumers must qualify on wr_en.
- Gaps in in_valid are legal at any byte position. There is no timeout.
- Reset mid-word: partial bytes are discarded and the state returns to IDLE. Already-written words stay in memory.
- HALT_WORD is compared only on complete 4-byte words. 0xFF bytes mid-word have no effect.

Decomposition:
- Shared package: loader state enum, HALT_WORD default, BYTES_PER_WORD=4 constant.
- One sub-module, word_assembler: 2-bit byte counter plus 32-bit shift register, with a word_valid pulse. The top level holds the FSM, address and count logic.

Test Plan:
1. Reset -> in_ready=0, wr_en=0, word_count=0, done=0, overflow_err=0, cpu_hold=1, busy=0.
2. start, then bytes 00 21 48 21 FF FF FF FF back-to-back -> two writes: (addr 0, 0x00214821) and (addr 1, 0xFFFFFFFF). Then done=1, word_count=2, cpu_hold=0, busy=0.
3. Same stream with 0–3 idle cycles between bytes, in_valid held during WRITE -> in_ready=0 in WRITE, identical writes, no byte lost or duplicated.
4. start, then 32 words 0x00000001..0x00000020 with no halt -> 32 writes to addr 0..31, then overflow_err=1, done=0, cpu_hold=1, word_count=32. A following start clears overflow_err and next writes addr 0.
5. rst_n low after 2 bytes of word 0, then start, then bytes 12 34 56 78 FF FF FF FF -> addr 0 = 0x12345678 and addr 1 = HALT; stale bytes absent.
6. start pulsed mid-COLLECT -> ignored, addr continues. start in DONE -> new load from addr 0, done drops, cpu_hold rises.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared state encoding and constants for the instruction memory loader.
package instr_mem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: shifts accepted bytes MSB-first into a word and pulses word_valid on the last byte.
module word_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      word_d = {word_q[DATA_W-9:0], in_byte};
    end
  end
  assign word_valid = accept && !clr && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign word       = word_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles big-endian words from a byte stream and writes them to instruction memory,
// holding the CPU until a halt word has been written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int              DEPTH     = 32,
  parameter int              ADDR_W    = 5,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic              cpu_hold
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, word;
  logic [ADDR_W:0]   count_q, count_d;
  logic              clr, word_valid;

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .accept    (in_valid && in_ready),
    .in_byte   (in_byte),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    clr     = 1'b0;
    unique case (state_q)
      S_COLLECT: state_d = word_valid ? S_WRITE : S_COLLECT;
      S_WRITE: begin
        count_d = count_q + 1'b1;
        if (word == HALT_WORD) state_d = S_DONE;
        else if (addr_q == ADDR_W'(DEPTH - 1)) state_d = S_ERROR;
        else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      default: if (start) begin
        state_d = S_COLLECT;
        addr_d  = '0;
        count_d = '0;
        clr     = 1'b1;
      end
    endcase
  end

  // Write port outputs freeze at the last written value between strobes.
  assign wr_en        = state_q == S_WRITE;
  assign wr_addr_d    = wr_en ? addr_q : wr_addr_q;
  assign wr_data_d    = wr_en ? word : wr_data_q;
  assign wr_addr      = wr_addr_d;
  assign wr_data      = wr_data_d;
  assign in_ready     = state_q == S_COLLECT;
  assign busy         = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done         = state_q == S_DONE;
  assign overflow_err = state_q == S_ERROR;
  assign cpu_hold     = state_q != S_DONE;
  assign word_count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scenarios for the instruction memory loader with a write-port log.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, busy, done, overflow_err, cpu_hold;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  word_count;

  int tests = 0;
  int fails = 0;
  int log_n = 0;
  int ovlp = 0;
  logic [4:0]  log_a [0:255];
  logic [31:0] log_d [0:255];

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .busy(busy), .done(done), .overflow_err(overflow_err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (log_n < 256) begin
        log_a[log_n] = wr_addr;
        log_d[log_n] = wr_data;
      end
      log_n = log_n + 1;
      if (in_ready) ovlp = ovlp + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %02h, required 1", b);
    end
    @(negedge clk);
  endtask

  task automatic wait_end();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (!(done || overflow_err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL wait_end: done=%0b overflow_err=%0b after 200 cycles, required one set", done, overflow_err);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, wr_en, done, overflow_err, cpu_hold, busy} !== 6'b000010 || word_count !== 6'd0
        || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      fails++;
      $display("FAIL reset: rdy/wr/done/ovf/hold/busy=%06b cnt=%0d addr=%0d data=%h, required 000010 0 0 0",
               {in_ready, wr_en, done, overflow_err, cpu_hold, busy}, word_count, wr_addr, wr_data);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [0:1];
    logic [7:0]  s [0:7];
    int base;
    exp_d = '{32'h0021_4821, 32'hFFFF_FFFF};
    s = '{8'h00, 8'h21, 8'h48, 8'h21, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    base = log_n;
    pulse_start();
    for (int i = 0; i < 4; i++) send(s[i], 0);
    tests++;
    if (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0021_4821) begin
      fails++;
      $display("FAIL basic_latency: wr_en=%0b rdy=%0b addr=%0d data=%h, required 1 0 0 00214821",
               wr_en, in_ready, wr_addr, wr_data);
    end
    for (int i = 4; i < 8; i++) send(s[i], 0);
    wait_end();
    tests++;
    if (log_n - base !== 2) begin
      fails++;
      $display("FAIL basic_nwrites: %0d, required 2", log_n - base);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (log_a[base+i] !== 5'(i) || log_d[base+i] !== exp_d[i]) begin
        fails++;
        $display("FAIL basic_write%0d: addr=%0d data=%h, required %0d %h", i, log_a[base+i], log_d[base+i], i, exp_d[i]);
      end
    end
    tests++;
    if ({done, overflow_err, cpu_hold, busy, in_ready} !== 5'b10000 || word_count !== 6'd2) begin
      fails++;
      $display("FAIL basic_done: done/ovf/hold/busy/rdy=%05b cnt=%0d, required 10000 2",
               {done, overflow_err, cpu_hold, busy, in_ready}, word_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 6'd2 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL basic_stable: done=%0b hold=%0b cnt=%0d wr_en=%0b, required 1 0 2 0", done, cpu_hold, word_count, wr_en);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] exp_d [0:1];
    logic [7:0]  s [0:7];
    int base;
    exp_d = '{32'h0021_4821, 32'hFFFF_FFFF};
    s = '{8'h00, 8'h21, 8'h48, 8'h21, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    base = log_n;
    ovlp = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) send(s[i], (i == 4) ? 0 : (i * 3) % 4);
    wait_end();
    tests++;
    if (log_n - base !== 2 || ovlp !== 0) begin
      fails++;
      $display("FAIL gaps_nwrites: writes=%0d ready_in_write=%0d, required 2 0", log_n - base, ovlp);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (log_a[base+i] !== 5'(i) || log_d[base+i] !== exp_d[i]) begin
        fails++;
        $display("FAIL gaps_write%0d: addr=%0d data=%h, required %0d %h", i, log_a[base+i], log_d[base+i], i, exp_d[i]);
      end
    end
    tests++;
    if (done !== 1'b1 || word_count !== 6'd2) begin
      fails++;
      $display("FAIL gaps_done: done=%0b cnt=%0d, required 1 2", done, word_count);
    end
  endtask

  task automatic test_overflow();
    int base;
    int bad;
    base = log_n;
    pulse_start();
    for (int w = 1; w <= 32; w++) begin
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'(w), 0);
    end
    wait_end();
    tests++;
    if (log_n - base !== 32) begin
      fails++;
      $display("FAIL ovf_nwrites: %0d, required 32", log_n - base);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (log_a[base+i] !== 5'(i) || log_d[base+i] !== 32'(i + 1)) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL ovf_writes: %0d wrong entries, required 0", bad);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({overflow_err, done, cpu_hold, busy, in_ready} !== 5'b10100 || word_count !== 6'd32 || log_n - base !== 32) begin
      fails++;
      $display("FAIL ovf_state: ovf/done/hold/busy/rdy=%05b cnt=%0d writes=%0d, required 10100 32 32",
               {overflow_err, done, cpu_hold, busy, in_ready}, word_count, log_n - base);
    end
    base = log_n;
    pulse_start();
    tests++;
    if (overflow_err !== 1'b0 || busy !== 1'b1 || word_count !== 6'd0) begin
      fails++;
      $display("FAIL ovf_restart: ovf=%0b busy=%0b cnt=%0d, required 0 1 0", overflow_err, busy, word_count);
    end
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    wait_end();
    tests++;
    if (log_n - base !== 1 || log_a[base] !== 5'd0 || log_d[base] !== 32'hFFFF_FFFF || done !== 1'b1) begin
      fails++;
      $display("FAIL ovf_reload: writes=%0d addr=%0d data=%h done=%0b, required 1 0 ffffffff 1",
               log_n - base, log_a[base], log_d[base], done);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0]  s [0:7];
    int base;
    s = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    send(8'hAA, 0);
    send(8'hBB, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({in_ready, busy, done, overflow_err, cpu_hold} !== 5'b00001 || word_count !== 6'd0) begin
      fails++;
      $display("FAIL midreset_state: rdy/busy/done/ovf/hold=%05b cnt=%0d, required 00001 0",
               {in_ready, busy, done, overflow_err, cpu_hold}, word_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    base = log_n;
    pulse_start();
    for (int i = 0; i < 8; i++) send(s[i], 0);
    wait_end();
    tests++;
    if (log_n - base !== 2 || log_a[base] !== 5'd0 || log_d[base] !== 32'h1234_5678
        || log_a[base+1] !== 5'd1 || log_d[base+1] !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL midreset_writes: n=%0d w0=%0d/%h w1=%0d/%h, required 2 0/12345678 1/ffffffff",
               log_n - base, log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0]  s [0:11];
    logic [31:0] exp_d [0:2];
    int base;
    s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_d = '{32'h1122_3344, 32'hAABB_CCDD, 32'hFFFF_FFFF};
    base = log_n;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      if (i == 2 || i == 6) begin
        in_valid = 1'b0;
        pulse_start();
      end
      send(s[i], 0);
    end
    wait_end();
    tests++;
    if (log_n - base !== 3 || word_count !== 6'd3) begin
      fails++;
      $display("FAIL ign_nwrites: writes=%0d cnt=%0d, required 3 3", log_n - base, word_count);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (log_a[base+i] !== 5'(i) || log_d[base+i] !== exp_d[i]) begin
        fails++;
        $display("FAIL ign_write%0d: addr=%0d data=%h, required %0d %h", i, log_a[base+i], log_d[base+i], i, exp_d[i]);
      end
    end
    base = log_n;
    pulse_start();
    tests++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_restart: done=%0b hold=%0b busy=%0b, required 0 1 1", done, cpu_hold, busy);
    end
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'hFF, 0);
    send(8'h00, 0);
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    wait_end();
    tests++;
    if (log_n - base !== 2 || log_a[base] !== 5'd0 || log_d[base] !== 32'hFFFF_FF00
        || log_a[base+1] !== 5'd1 || log_d[base+1] !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL done_reload: n=%0d w0=%0d/%h w1=%0d/%h, required 2 0/ffffff00 1/ffffffff",
               log_n - base, log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_gaps();
    test_overflow();
    test_reset_mid_word();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
